ttt_io_bridge: RTL and testbench

Parametrised host-pin front-end for the tick-tock-tokens core. It replaces direct pin-to-core wiring with two handshakes. Host commands are captured on a strobe toggle and held for the core under a valid/ready handshake. Core token events are queued in an output FIFO that the host drains with a pop toggle. It sits between the TinyTapeout pins and `ttt_main`, and adds decoding, range checking and sticky error reporting.

---
 rtl/ttt_pkg.sv | 33 +++
 rtl/ttt_io_bridge_if.sv | 39 +++
 rtl/ttt_event_fifo.sv | 50 +++++
 rtl/ttt_io_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_ttt_io_bridge.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tick-tock-tokens host bridge: opcodes, pin_out
// bit positions and error/status bit indices.
package ttt_pkg;

    typedef enum logic [3:0] {
        OP_NOP      = 4'b0000,
        OP_INPUT    = 4'b0001,
        OP_ADVANCE  = 4'b0010,
        OP_CLEAR    = 4'b0011,
        OP_PASS     = 4'b1000,
        OP_PROG_DUR = 4'b1001,
        OP_PROG_GTH = 4'b1010,
        OP_PROG_BTH = 4'b1011,
        OP_NET_GW   = 4'b1100,
        OP_NET_BW   = 4'b1101,
        OP_NET_PTR  = 4'b1110,
        OP_NET_IDX  = 4'b1111
    } ttt_op_e;

    localparam int PIN_OUT_PROC_LSB  = 4;
    localparam int PIN_OUT_SS_LSB    = 2;
    localparam int PIN_OUT_STAGE_LSB = 0;

    localparam int ERR_ILLEGAL     = 0;
    localparam int ERR_OVERFLOW    = 1;
    localparam int ERR_OVERRUN     = 2;
    localparam int STATUS_NONEMPTY = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ttt_io_bridge_if.sv
// Command and event bus between the host bridge (master) and the core (slave).
interface ttt_io_bridge_if #(
    parameter int NUM_PROCESSORS  = 8,
    parameter int NUM_CONNECTIONS = 32,
    parameter int NEW_TOKEN_BITS  = 2,
    parameter int TOKEN_BITS      = 7,
    parameter int DURATION_BITS   = 7
);
    import ttt_pkg::*;

    localparam int PROC_BITS  = $clog2(NUM_PROCESSORS);
    localparam int CONN_BITS  = $clog2(NUM_CONNECTIONS);
    localparam int VALUE_BITS = max_int(TOKEN_BITS, DURATION_BITS);

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [3:0]                cmd_op;
    logic [PROC_BITS-1:0]      cmd_proc;
    logic [CONN_BITS-1:0]      cmd_conn;
    logic [NEW_TOKEN_BITS-1:0] cmd_good;
    logic [NEW_TOKEN_BITS-1:0] cmd_bad;
    logic [VALUE_BITS-1:0]     cmd_value;

    logic                      ev_valid;
    logic [PROC_BITS-1:0]      ev_proc;
    logic [1:0]                ev_startstop;
    logic [1:0]                core_stage;

    modport master (
        output cmd_valid, cmd_op, cmd_proc, cmd_conn, cmd_good, cmd_bad, cmd_value,
        input  cmd_ready, ev_valid, ev_proc, ev_startstop, core_stage
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_proc, cmd_conn, cmd_good, cmd_bad, cmd_value,
        output cmd_ready, ev_valid, ev_proc, ev_startstop, core_stage
    );

endinterface

// File: rtl/ttt_event_fifo.sv
// Power-of-two event FIFO; pointers carry an extra wrap bit so full and empty
// are told apart without a separate count.
module ttt_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign overflow_o = push_i && !do_push;

    assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ttt_io_bridge.sv
// Host-pin front-end for ttt_main: toggle-strobed command capture with a
// one-entry command slot, an event FIFO drained by pop toggles, sticky errors.
module ttt_io_bridge
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS  = 8,
    parameter int NUM_CONNECTIONS = 32,
    parameter int NEW_TOKEN_BITS  = 2,
    parameter int TOKEN_BITS      = 7,
    parameter int DURATION_BITS   = 7,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  pin_op,
    input  logic [11:0] pin_data,
    input  logic        pin_strobe,
    input  logic        pin_pop,
    output logic [7:0]  pin_out,
    output logic [3:0]  pin_status,
    ttt_io_bridge_if.master io
);
    localparam int PROC_BITS  = $clog2(NUM_PROCESSORS);
    localparam int CONN_BITS  = $clog2(NUM_CONNECTIONS);
    localparam int VALUE_BITS = max_int(TOKEN_BITS, DURATION_BITS);
    localparam int EV_W       = PROC_BITS + 2;

    logic                      strobe_q;
    logic                      pop_q;
    logic [1:0]                stage_q;
    logic [2:0]                err_q, err_d;
    logic                      valid_q, valid_d;
    logic [3:0]                op_q, op_d;
    logic [PROC_BITS-1:0]      proc_q, proc_d;
    logic [CONN_BITS-1:0]      conn_q, conn_d;
    logic [NEW_TOKEN_BITS-1:0] good_q, good_d;
    logic [NEW_TOKEN_BITS-1:0] bad_q, bad_d;
    logic [VALUE_BITS-1:0]     value_q, value_d;

    logic [3:0]                hi;
    logic [7:0]                lo;
    logic                      detect;
    logic                      dec_fwd, dec_clear, dec_bad_op, dec_proc_op, dec_conn_op;
    logic                      dec_illegal;
    logic [PROC_BITS-1:0]      dec_proc;
    logic [CONN_BITS-1:0]      dec_conn;
    logic [NEW_TOKEN_BITS-1:0] dec_good, dec_bad;
    logic [VALUE_BITS-1:0]     dec_value;
    logic [2:0]                err_new;

    logic                      ev_push, ev_pop;
    logic [EV_W-1:0]           head;
    logic                      fifo_empty, fifo_full_unused, fifo_overflow;
    logic [PROC_BITS-1:0]      head_proc;
    logic [1:0]                head_ss;

    assign hi     = pin_data[11:8];
    assign lo     = pin_data[7:0];
    assign detect = (pin_strobe != strobe_q);

    always_comb begin
        dec_fwd     = 1'b0;
        dec_clear   = 1'b0;
        dec_bad_op  = 1'b0;
        dec_proc_op = 1'b0;
        dec_conn_op = 1'b0;
        dec_proc    = '0;
        dec_conn    = '0;
        dec_good    = '0;
        dec_bad     = '0;
        dec_value   = '0;
        case (pin_op)
            OP_NOP, OP_ADVANCE, OP_PASS: dec_fwd = 1'b1;
            OP_CLEAR: dec_clear = 1'b1;
            OP_INPUT: begin
                dec_fwd     = 1'b1;
                dec_proc_op = 1'b1;
                dec_proc    = PROC_BITS'(hi);
                dec_good    = NEW_TOKEN_BITS'(lo[7:4]);
                dec_bad     = NEW_TOKEN_BITS'(lo[3:0]);
            end
            OP_PROG_DUR, OP_PROG_GTH, OP_PROG_BTH: begin
                dec_fwd     = 1'b1;
                dec_proc_op = 1'b1;
                dec_proc    = PROC_BITS'(hi);
                dec_value   = VALUE_BITS'(lo);
            end
            OP_NET_GW: begin
                dec_fwd     = 1'b1;
                dec_conn_op = 1'b1;
                dec_good    = NEW_TOKEN_BITS'(hi);
                dec_conn    = CONN_BITS'(lo);
            end
            OP_NET_BW: begin
                dec_fwd     = 1'b1;
                dec_conn_op = 1'b1;
                dec_bad     = NEW_TOKEN_BITS'(hi);
                dec_conn    = CONN_BITS'(lo);
            end
            OP_NET_PTR, OP_NET_IDX: begin
                dec_fwd     = 1'b1;
                dec_proc_op = 1'b1;
                dec_conn_op = 1'b1;
                dec_proc    = PROC_BITS'(hi);
                dec_conn    = CONN_BITS'(lo);
            end
            default: dec_bad_op = 1'b1;
        endcase
        dec_illegal = dec_bad_op
                   || (dec_proc_op && (32'(hi) >= NUM_PROCESSORS))
                   || (dec_conn_op && (32'(lo) >= NUM_CONNECTIONS));
    end

    // Slot frees and reloads in one cycle when the core accepts as a new
    // command arrives; only a held slot turns a new command into an overrun.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        proc_d  = proc_q;
        conn_d  = conn_q;
        good_d  = good_q;
        bad_d   = bad_q;
        value_d = value_q;
        err_new = '0;
        if (valid_q && io.cmd_ready) begin
            valid_d = 1'b0;
            op_d    = '0;
            proc_d  = '0;
            conn_d  = '0;
            good_d  = '0;
            bad_d   = '0;
            value_d = '0;
        end
        if (detect) begin
            if (dec_illegal) begin
                err_new[ERR_ILLEGAL] = 1'b1;
            end else if (dec_fwd) begin
                if (!valid_q || io.cmd_ready) begin
                    valid_d = 1'b1;
                    op_d    = pin_op;
                    proc_d  = dec_proc;
                    conn_d  = dec_conn;
                    good_d  = dec_good;
                    bad_d   = dec_bad;
                    value_d = dec_value;
                end else begin
                    err_new[ERR_OVERRUN] = 1'b1;
                end
            end
        end
        err_new[ERR_OVERFLOW] = fifo_overflow;
        err_d = ((detect && dec_clear) ? 3'b000 : err_q) | err_new;
    end

    // Edge-detect registers follow the pins even in reset so held levels
    // never look like a toggle once reset releases.
    always_ff @(posedge clk) begin
        strobe_q <= pin_strobe;
        pop_q    <= pin_pop;
        if (!rst_n) begin
            stage_q <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            op_q    <= '0;
            proc_q  <= '0;
            conn_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            value_q <= '0;
        end else begin
            stage_q <= io.core_stage;
            err_q   <= err_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            proc_q  <= proc_d;
            conn_q  <= conn_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            value_q <= value_d;
        end
    end

    assign ev_push = io.ev_valid && (io.ev_startstop != 2'b00);
    assign ev_pop  = (pin_pop != pop_q);

    ttt_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (ev_push),
        .pop_i      (ev_pop),
        .data_i     ({io.ev_proc, io.ev_startstop}),
        .data_o     (head),
        .full_o     (fifo_full_unused),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_overflow)
    );

    assign head_proc = head[EV_W-1:2];
    assign head_ss   = head[1:0];

    always_comb begin
        pin_out = '0;
        pin_out[PIN_OUT_PROC_LSB +: 4]  = 4'(head_proc);
        pin_out[PIN_OUT_SS_LSB +: 2]    = head_ss;
        pin_out[PIN_OUT_STAGE_LSB +: 2] = stage_q;
        pin_status = '0;
        pin_status[STATUS_NONEMPTY] = !fifo_empty;
        pin_status[ERR_OVERRUN]     = err_q[ERR_OVERRUN];
        pin_status[ERR_OVERFLOW]    = err_q[ERR_OVERFLOW];
        pin_status[ERR_ILLEGAL]     = err_q[ERR_ILLEGAL];
    end

    assign io.cmd_valid = valid_q;
    assign io.cmd_op    = op_q;
    assign io.cmd_proc  = proc_q;
    assign io.cmd_conn  = conn_q;
    assign io.cmd_good  = good_q;
    assign io.cmd_bad   = bad_q;
    assign io.cmd_value = value_q;

endmodule

// File: tb/tb_ttt_io_bridge.sv
// Directed plus randomized bench for ttt_io_bridge against a queue-based
// behavioural model of the command slot, event FIFO and error flags.
module tb_ttt_io_bridge;
    localparam int NP    = 8;
    localparam int NC    = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pin_op;
    logic [11:0] pin_data;
    logic        pin_strobe;
    logic        pin_pop;
    logic [7:0]  pin_out;
    logic [3:0]  pin_status;

    always #5 clk = ~clk;

    ttt_io_bridge_if #(
        .NUM_PROCESSORS(NP), .NUM_CONNECTIONS(NC), .NEW_TOKEN_BITS(2),
        .TOKEN_BITS(7), .DURATION_BITS(7)
    ) bus ();

    ttt_io_bridge #(
        .NUM_PROCESSORS(NP), .NUM_CONNECTIONS(NC), .NEW_TOKEN_BITS(2),
        .TOKEN_BITS(7), .DURATION_BITS(7), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin_op     (pin_op),
        .pin_data   (pin_data),
        .pin_strobe (pin_strobe),
        .pin_pop    (pin_pop),
        .pin_out    (pin_out),
        .pin_status (pin_status),
        .io         (bus)
    );

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int   m_valid, m_op, m_proc, m_conn, m_good, m_bad, m_value;
    int   m_ill, m_ovr, m_ovf, m_stage;
    int   q_proc[$];
    int   q_ss[$];
    logic m_strobe, m_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int o, hi, lo;
        bit busy, clr, pb, cb, popped, full;
        bit ne_ill, ne_ovr, ne_ovf;
        if (!rst_n) begin
            m_valid = 0; m_op = 0; m_proc = 0; m_conn = 0; m_good = 0; m_bad = 0; m_value = 0;
            m_ill = 0; m_ovr = 0; m_ovf = 0; m_stage = 0;
            q_proc.delete(); q_ss.delete();
        end else begin
            ne_ill = 0; ne_ovr = 0; ne_ovf = 0; clr = 0;
            busy = (m_valid != 0) && !bus.cmd_ready;
            if (m_valid != 0 && bus.cmd_ready) m_valid = 0;
            if (pin_strobe != m_strobe) begin
                o  = int'(pin_op);
                hi = int'(pin_data[11:8]);
                lo = int'(pin_data[7:0]);
                if (o == 3) clr = 1;
                else if (o >= 4 && o <= 7) ne_ill = 1;
                else begin
                    pb = (o == 1) || (o >= 9 && o <= 11) || (o >= 14);
                    cb = (o >= 12);
                    if ((pb && hi >= NP) || (cb && lo >= NC)) ne_ill = 1;
                    else if (busy) ne_ovr = 1;
                    else begin
                        m_valid = 1;
                        m_op    = o;
                        m_proc  = pb ? hi : 0;
                        m_conn  = cb ? lo : 0;
                        m_good  = (o == 1) ? (lo / 16) % 4 : (o == 12) ? hi % 4 : 0;
                        m_bad   = (o == 1) ? lo % 4 : (o == 13) ? hi % 4 : 0;
                        m_value = (o >= 9 && o <= 11) ? lo % 128 : 0;
                    end
                end
            end
            full   = (q_proc.size() == DEPTH);
            popped = (pin_pop != m_pop) && (q_proc.size() > 0);
            if (popped) begin
                void'(q_proc.pop_front());
                void'(q_ss.pop_front());
            end
            if (bus.ev_valid && bus.ev_startstop != 2'b00) begin
                if (full && !popped) ne_ovf = 1;
                else begin
                    q_proc.push_back(int'(bus.ev_proc));
                    q_ss.push_back(int'(bus.ev_startstop));
                end
            end
            if (clr) begin m_ill = 0; m_ovr = 0; m_ovf = 0; end
            if (ne_ill) m_ill = 1;
            if (ne_ovr) m_ovr = 1;
            if (ne_ovf) m_ovf = 1;
            m_stage = int'(bus.core_stage);
        end
        m_strobe = pin_strobe;
        m_pop    = pin_pop;
    endtask

    task automatic check_all();
        int exp_out, exp_st;
        check("cmd_valid", 32'(bus.cmd_valid), m_valid);
        if (m_valid != 0) begin
            check("cmd_op",    32'(bus.cmd_op),    m_op);
            check("cmd_proc",  32'(bus.cmd_proc),  m_proc);
            check("cmd_conn",  32'(bus.cmd_conn),  m_conn);
            check("cmd_good",  32'(bus.cmd_good),  m_good);
            check("cmd_bad",   32'(bus.cmd_bad),   m_bad);
            check("cmd_value", 32'(bus.cmd_value), m_value);
        end
        exp_out = m_stage;
        if (q_proc.size() > 0) exp_out += q_proc[0] * 16 + q_ss[0] * 4;
        check("pin_out", 32'(pin_out), exp_out);
        exp_st = ((q_proc.size() > 0) ? 8 : 0) + m_ovr * 4 + m_ovf * 2 + m_ill;
        check("pin_status", 32'(pin_status), exp_st);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input int op, input int data);
        pin_op     = op[3:0];
        pin_data   = data[11:0];
        pin_strobe = ~pin_strobe;
    endtask

    task automatic event_in(input int proc, input int ss);
        bus.ev_valid     = 1'b1;
        bus.ev_proc      = proc[2:0];
        bus.ev_startstop = ss[1:0];
    endtask

    initial begin
        rst_n = 1'b0; pin_op = '0; pin_data = '0;
        pin_strobe = 1'b1; pin_pop = 1'b1;
        bus.cmd_ready = 1'b0; bus.ev_valid = 1'b0; bus.ev_proc = '0;
        bus.ev_startstop = '0; bus.core_stage = '0;

        // pins held high across reset, then released
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("idle_out", 32'(pin_out), 0);
        check("idle_status", 32'(pin_status), 0);

        // held command then handshake
        send(9, 'h305);
        tick(); tick(); tick();
        check("prog_proc", 32'(bus.cmd_proc), 3);
        check("prog_value", 32'(bus.cmd_value), 5);
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        tick();

        // illegal proc, then clear
        send(10, 'h905); tick(); tick();
        send(3, 0); tick();
        // illegal opcode and illegal connection
        send(5, 'h123); tick();
        send(15, 'h120); tick();
        send(3, 0); tick();

        // overrun, then a command landing on the handshake cycle
        send(1, 'h2A5); tick();
        send(14, 'h11F); tick();
        bus.cmd_ready = 1'b1;
        send(12, 'h31E); tick();
        bus.cmd_ready = 1'b0;
        tick();
        bus.cmd_ready = 1'b1; tick();
        send(13, 'hF1F); tick();
        send(3, 0); tick();
        bus.cmd_ready = 1'b0;
        bus.core_stage = 2'd2;

        // overflow with five pushes, then drain
        for (int i = 0; i < 5; i++) begin
            event_in(i + 1, (i % 3) + 1);
            tick();
        end
        bus.ev_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pin_pop = ~pin_pop;
            tick();
        end
        check("drained_head", 32'(pin_out[7:2]), 0);
        pin_pop = ~pin_pop; tick();
        event_in(7, 0); tick();
        event_in(2, 3); pin_pop = ~pin_pop; tick();
        bus.ev_valid = 1'b0;
        pin_pop = ~pin_pop; tick();
        send(3, 0); tick();

        // push onto full FIFO with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            event_in(i, 2);
            tick();
        end
        event_in(6, 1); pin_pop = ~pin_pop; tick();
        bus.ev_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pin_pop = ~pin_pop;
            tick();
        end
        check("wrap_head", 32'(pin_out[7:2]), 6 * 4 + 1);
        pin_pop = ~pin_pop; tick();

        // reset mid-operation discards command and events
        send(2, 0); event_in(4, 1); tick();
        bus.ev_valid = 1'b0;
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n            = ($urandom_range(0, 99) != 0);
            bus.cmd_ready    = 1'($urandom_range(0, 1));
            bus.ev_valid     = ($urandom_range(0, 2) != 0);
            bus.ev_proc      = 3'($urandom_range(0, 7));
            bus.ev_startstop = 2'($urandom_range(0, 3));
            bus.core_stage   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0)
                send($urandom_range(0, 15),
                     $urandom_range(0, 9) * 256 + $urandom_range(0, 40));
            if ($urandom_range(0, 2) == 0) pin_pop = ~pin_pop;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
